// File: rtl/calc_seq_engine.sv
// calc_seq_engine: BCD keypad calculator with binary arithmetic and double-dabble display conversion.
// Optional sequential multiplier (key C) is built only when CALC_MUL_EN is defined.
module calc_seq_engine #(
   parameter int unsigned DIGITS = 4,
   parameter int unsigned BIN_W  = 14
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  key_valid,
   input  logic [3:0]            key_code,
   output logic [4*DIGITS-1:0]   disp_bcd,
   output logic                  f_sig_res,
   output logic                  f_OF,
   output logic                  busy,
   output logic                  result_valid
);
   localparam int unsigned BCD_W = 4*DIGITS;
   localparam int unsigned PW    = 2*BIN_W;
   localparam int unsigned CW    = $clog2(BIN_W+1);
   localparam int unsigned DCW   = $clog2(DIGITS+1);
   localparam longint unsigned MAXV64 = 64'(10**DIGITS) - 64'd1;
   localparam logic [PW-1:0] MAXV = PW'(MAXV64);

   if ((64'd1 << BIN_W) <= MAXV64) begin : g_bin_w_chk
      $error("calc_seq_engine: BIN_W too small to hold 10**DIGITS-1");
   end

   typedef enum logic [2:0] {S_OP1, S_OP2, S_CALC, S_CONV, S_SHOW} state_e;
   typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL} op_e;

   state_e             state_q, state_d;
   op_e                op_q, op_d, op_key;
   logic [BCD_W-1:0]   op1_bcd_q, op1_bcd_d, op2_bcd_q, op2_bcd_d;
   logic [BIN_W-1:0]   op1_bin_q, op1_bin_d, op2_bin_q, op2_bin_d;
   logic [DCW-1:0]     dcnt_q, dcnt_d;
   logic [CW-1:0]      iter_q, iter_d;
   logic [BCD_W-1:0]   dd_bcd_q, dd_bcd_d, res_bcd_q, res_bcd_d, adj;
   logic [BIN_W-1:0]   dd_bin_q, dd_bin_d, res_bin_q, res_bin_d, fin_bin;
   logic               neg_q, neg_d, of_q, of_d;
   logic               f_sig_q, f_sig_d, f_of_q, f_of_d, rv_q, rv_d;
   logic               key_ok, is_dig, is_op, is_eq, is_clr, room;
   logic               do_clear, calc_done, calc_neg, ovf;
   logic [PW-1:0]      mag;
`ifdef CALC_MUL_EN
   logic [PW-1:0]      mcand_q, mcand_d, prod_q, prod_d, prod_nxt;
   logic [BIN_W-1:0]   mplier_q, mplier_d;
`endif

   assign busy   = (state_q == S_CALC) || (state_q == S_CONV);
   assign key_ok = key_valid && !busy;
   assign is_dig = key_code <= 4'd9;
   assign is_eq  = key_code == 4'hD;
   assign is_clr = key_code == 4'hE;
   assign room   = dcnt_q != DCW'(DIGITS);
`ifdef CALC_MUL_EN
   assign is_op  = (key_code == 4'hA) || (key_code == 4'hB) || (key_code == 4'hC);
   assign op_key = (key_code == 4'hB) ? OP_SUB : (key_code == 4'hC) ? OP_MUL : OP_ADD;
`else
   assign is_op  = (key_code == 4'hA) || (key_code == 4'hB);
   assign op_key = (key_code == 4'hB) ? OP_SUB : OP_ADD;
`endif

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      op1_bcd_d = op1_bcd_q;
      op1_bin_d = op1_bin_q;
      op2_bcd_d = op2_bcd_q;
      op2_bin_d = op2_bin_q;
      dcnt_d    = dcnt_q;
      iter_d    = iter_q;
      dd_bcd_d  = dd_bcd_q;
      dd_bin_d  = dd_bin_q;
      res_bcd_d = res_bcd_q;
      res_bin_d = res_bin_q;
      neg_d     = neg_q;
      of_d      = of_q;
      f_sig_d   = f_sig_q;
      f_of_d    = f_of_q;
      rv_d      = 1'b0;
      do_clear  = 1'b0;
      calc_done = 1'b0;
      calc_neg  = 1'b0;
      mag       = '0;
      ovf       = 1'b0;
      fin_bin   = '0;
      adj       = dd_bcd_q;
`ifdef CALC_MUL_EN
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      prod_d    = prod_q;
      prod_nxt  = prod_q + (mplier_q[0] ? mcand_q : '0);
`endif
      case (state_q)
         S_OP1: if (key_ok) begin
            if (is_dig) begin
               if (room) begin
                  op1_bcd_d = (op1_bcd_q << 4) | BCD_W'(key_code);
                  op1_bin_d = op1_bin_q * BIN_W'(10) + BIN_W'(key_code);
                  dcnt_d    = dcnt_q + DCW'(1);
               end
            end else if (is_op) begin
               op_d      = op_key;
               op2_bcd_d = '0;
               op2_bin_d = '0;
               dcnt_d    = '0;
               state_d   = S_OP2;
            end else if (is_clr) begin
               do_clear = 1'b1;
            end
         end
         S_OP2: if (key_ok) begin
            if (is_dig) begin
               if (room) begin
                  op2_bcd_d = (op2_bcd_q << 4) | BCD_W'(key_code);
                  op2_bin_d = op2_bin_q * BIN_W'(10) + BIN_W'(key_code);
                  dcnt_d    = dcnt_q + DCW'(1);
               end
            end else if (is_op) begin
               op_d = op_key;
            end else if (is_eq) begin
               iter_d  = '0;
               state_d = S_CALC;
`ifdef CALC_MUL_EN
               mcand_d  = PW'(op1_bin_q);
               mplier_d = op2_bin_q;
               prod_d   = '0;
`endif
            end else if (is_clr) begin
               do_clear = 1'b1;
            end
         end
         S_CALC: begin
            case (op_q)
               OP_SUB: begin
                  calc_done = 1'b1;
                  if (op1_bin_q < op2_bin_q) begin
                     mag      = PW'(op2_bin_q - op1_bin_q);
                     calc_neg = 1'b1;
                  end else begin
                     mag = PW'(op1_bin_q - op2_bin_q);
                  end
               end
`ifdef CALC_MUL_EN
               OP_MUL: begin
                  prod_d    = prod_nxt;
                  mcand_d   = mcand_q << 1;
                  mplier_d  = mplier_q >> 1;
                  iter_d    = iter_q + CW'(1);
                  calc_done = iter_q == CW'(BIN_W-1);
                  mag       = prod_nxt;
               end
`endif
               default: begin
                  calc_done = 1'b1;
                  mag       = PW'({1'b0, op1_bin_q} + {1'b0, op2_bin_q});
               end
            endcase
            // Overflowed magnitudes are converted as zero.
            if (calc_done) begin
               ovf       = mag > MAXV;
               fin_bin   = ovf ? '0 : mag[BIN_W-1:0];
               of_d      = ovf;
               neg_d     = calc_neg;
               res_bin_d = fin_bin;
               dd_bin_d  = fin_bin;
               dd_bcd_d  = '0;
               iter_d    = '0;
               state_d   = S_CONV;
            end
         end
         S_CONV: begin
            if (iter_q == CW'(BIN_W)) begin
               res_bcd_d = dd_bcd_q;
               f_sig_d   = neg_q;
               f_of_d    = of_q;
               rv_d      = 1'b1;
               state_d   = S_SHOW;
            end else begin
               for (int unsigned i = 0; i < DIGITS; i++) begin
                  if (dd_bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = dd_bcd_q[4*i +: 4] + 4'd3;
               end
               dd_bcd_d = BCD_W'({adj, dd_bin_q[BIN_W-1]});
               dd_bin_d = dd_bin_q << 1;
               iter_d   = iter_q + CW'(1);
            end
         end
         S_SHOW: if (key_ok) begin
            if (is_dig) begin
               op1_bcd_d = BCD_W'(key_code);
               op1_bin_d = BIN_W'(key_code);
               op2_bcd_d = '0;
               op2_bin_d = '0;
               dcnt_d    = DCW'(1);
               f_sig_d   = 1'b0;
               f_of_d    = 1'b0;
               state_d   = S_OP1;
            end else if (is_op) begin
               if (!f_sig_q && !f_of_q) begin
                  op1_bcd_d = res_bcd_q;
                  op1_bin_d = res_bin_q;
                  op2_bcd_d = '0;
                  op2_bin_d = '0;
                  dcnt_d    = '0;
                  op_d      = op_key;
                  state_d   = S_OP2;
               end
            end else if (is_clr) begin
               do_clear = 1'b1;
            end
         end
         default: state_d = S_OP1;
      endcase
      if (do_clear) begin
         op1_bcd_d = '0;
         op1_bin_d = '0;
         op2_bcd_d = '0;
         op2_bin_d = '0;
         dcnt_d    = '0;
         f_sig_d   = 1'b0;
         f_of_d    = 1'b0;
         state_d   = S_OP1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_OP1;
         op_q      <= OP_ADD;
         op1_bcd_q <= '0;
         op1_bin_q <= '0;
         op2_bcd_q <= '0;
         op2_bin_q <= '0;
         dcnt_q    <= '0;
         iter_q    <= '0;
         dd_bcd_q  <= '0;
         dd_bin_q  <= '0;
         res_bcd_q <= '0;
         res_bin_q <= '0;
         neg_q     <= 1'b0;
         of_q      <= 1'b0;
         f_sig_q   <= 1'b0;
         f_of_q    <= 1'b0;
         rv_q      <= 1'b0;
`ifdef CALC_MUL_EN
         mcand_q   <= '0;
         mplier_q  <= '0;
         prod_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         op1_bcd_q <= op1_bcd_d;
         op1_bin_q <= op1_bin_d;
         op2_bcd_q <= op2_bcd_d;
         op2_bin_q <= op2_bin_d;
         dcnt_q    <= dcnt_d;
         iter_q    <= iter_d;
         dd_bcd_q  <= dd_bcd_d;
         dd_bin_q  <= dd_bin_d;
         res_bcd_q <= res_bcd_d;
         res_bin_q <= res_bin_d;
         neg_q     <= neg_d;
         of_q      <= of_d;
         f_sig_q   <= f_sig_d;
         f_of_q    <= f_of_d;
         rv_q      <= rv_d;
`ifdef CALC_MUL_EN
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         prod_q    <= prod_d;
`endif
      end
   end

   always_comb begin
      case (state_q)
         S_OP1:   disp_bcd = op1_bcd_q;
         S_SHOW:  disp_bcd = res_bcd_q;
         default: disp_bcd = op2_bcd_q;
      endcase
   end

   assign f_sig_res    = f_sig_q;
   assign f_OF         = f_of_q;
   assign result_valid = rv_q;

endmodule
